i2c_cfg_master: RTL and testbench

Parametrised I2C write master for sensor/codec register configuration, the successor to the fixed 20 kHz / 32-bit configure block. It runs entirely on the system clock using a quarter-period clock-enable instead of a derived clock. Per transfer it sends a 7-bit address plus 0..MAX_BYTES data bytes, checks every ACK and reports NACK. It sits between a register-table sequencer (valid/ready source) and the board I2C pins.

---
 rtl/i2c_cfg_master_if.sv | 23 ++
 rtl/i2c_cfg_master.sv | 196 +++++++++++++++++++
 tb/tb_i2c_cfg_master.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_master_if.sv
// rtl/i2c_cfg_master_if.sv - request/result handshake between the config sequencer and i2c_cfg_master
interface i2c_cfg_master_if #(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [6:0]             cfg_addr;
  logic [8*MAX_BYTES-1:0] cfg_data;
  logic [LEN_W-1:0]       cfg_len;
  logic                   done;
  logic                   nack;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_len,
    input  cfg_ready, done, nack
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_len,
    output cfg_ready, done, nack
  );
endinterface

// File: rtl/i2c_cfg_master.sv
// rtl/i2c_cfg_master.sv - I2C write master: START, address byte, 0..MAX_BYTES data bytes with ACK check, STOP
module i2c_cfg_master #(
  parameter int CLK_FREQ  = 24_000_000,
  parameter int I2C_FREQ  = 20_000,
  parameter int MAX_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  i2c_cfg_master_if.slave cfg,
  output logic            i2c_sclk,
  inout  wire             i2c_sdat
);

  localparam int QDIV  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW    = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int DW    = 8 * MAX_BYTES;
  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam logic [QW-1:0]    QMAX    = QW'(QDIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

  generate
    if (QDIV < 2) begin : g_qdiv_chk
      $error("i2c_cfg_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end
    if (MAX_BYTES < 1 || MAX_BYTES > 7) begin : g_max_chk
      $error("i2c_cfg_master: MAX_BYTES must be in 1..7");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       shift_q, shift_d;
  logic [DW-1:0]    data_q, data_d;
  logic             nack_q, nack_d;
  logic             scl_q, scl_d;
  logic             sda_low_q, sda_low_d;
  logic [1:0]       sda_sync_q;

  logic tick;
  logic accept;
  logic busy;

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tick          = busy && (qcnt_q == QMAX);
  assign cfg.cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg.done      = (state_q == S_DONE);
  assign cfg.nack      = nack_q;

  assign i2c_sclk = scl_q;
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    data_d  = data_q;
    nack_d  = nack_q;

    if (!busy) begin
      qcnt_d  = '0;
      phase_d = 2'd0;
      if (state_q == S_DONE) begin
        state_d = S_IDLE;
      end
    end else begin
      qcnt_d = tick ? '0 : qcnt_q + QW'(1);
      if (tick) begin
        phase_d = phase_q + 2'd1;
      end

      // ACK is sampled at the end of the first SCL-high quarter
      if (state_q == S_ACK && tick && phase_q == 2'd1 && sda_sync_q[1]) begin
        nack_d = 1'b1;
      end

      if (tick && phase_q == 2'd3) begin
        case (state_q)
          S_START: begin
            state_d = S_BIT;
            bit_d   = 3'd7;
          end
          S_BIT: begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_q == 3'd0) begin
              state_d = S_ACK;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
          S_ACK: begin
            if (nack_q || cnt_q == len_q) begin
              state_d = S_STOP;
            end else begin
              state_d = S_BIT;
              bit_d   = 3'd7;
              shift_d = data_q[DW-1 -: 8];
              data_d  = {data_q[DW-9:0], 8'h00};
              cnt_d   = cnt_q + LEN_W'(1);
            end
          end
          S_STOP:  state_d = S_DONE;
          default: state_d = S_IDLE;
        endcase
      end
    end

    // The address byte is preloaded so START only has to hand over to BIT
    if (accept) begin
      state_d = S_START;
      qcnt_d  = '0;
      phase_d = 2'd0;
      cnt_d   = '0;
      len_d   = (cfg.cfg_len > LEN_MAX) ? LEN_MAX : cfg.cfg_len;
      shift_d = {cfg.cfg_addr, 1'b0};
      data_d  = cfg.cfg_data;
      nack_d  = 1'b0;
    end
  end

  // Pin levels are decoded from the next state so they register in step with it
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: begin
        scl_d     = (phase_d != 2'd3);
        sda_low_d = phase_d[1];
      end
      S_BIT: begin
        scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_low_d = ~shift_d[7];
      end
      S_ACK: begin
        scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_low_d = 1'b0;
      end
      S_STOP: begin
        scl_d     = (phase_d != 2'd0);
        sda_low_d = ~phase_d[1];
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 3'd0;
      cnt_q      <= '0;
      len_q      <= '0;
      shift_q    <= 8'h00;
      data_q     <= '0;
      nack_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
      sda_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      nack_q     <= nack_d;
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
      sda_sync_q <= {sda_sync_q[0], i2c_sdat};
    end
  end

endmodule

// File: tb/tb_i2c_cfg_master.sv
// tb/tb_i2c_cfg_master.sv - directed bench for i2c_cfg_master with a byte-capturing I2C slave model
module tb_i2c_cfg_master;
  localparam int Q1 = 5;
  localparam int Q2 = 62;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_cfg_master_if #(.MAX_BYTES(4)) cif ();
  i2c_cfg_master_if #(.MAX_BYTES(4)) cif2 ();

  logic scl, scl2;
  wire  sda, sda2;
  pullup (sda);
  pullup (sda2);

  logic ack_drv = 1'b0;
  assign sda = ack_drv ? 1'b0 : 1'bz;

  i2c_cfg_master #(.CLK_FREQ(2_000_000), .I2C_FREQ(100_000), .MAX_BYTES(4)) dut (
    .clk(clk), .reset(reset), .cfg(cif), .i2c_sclk(scl), .i2c_sdat(sda)
  );

  i2c_cfg_master #(.CLK_FREQ(100_000_000), .I2C_FREQ(400_000), .MAX_BYTES(4)) dut2 (
    .clk(clk), .reset(reset), .cfg(cif2), .i2c_sclk(scl2), .i2c_sdat(sda2)
  );

  int ntests = 0;
  int nfail  = 0;

  // Slave model: captures wire bytes, ACKs every byte except byte number nack_at
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         bitn = 0, byte_no = 0, nack_at = -1, nstart = 0, nstop = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] rx[$];

  always @(negedge clk) begin
    if (scl && scl_p && sda_p && !sda) begin
      nstart++; bitn = 0; byte_no = 0; ack_drv = 1'b0;
    end else if (scl && scl_p && !sda_p && sda) begin
      nstop++; bitn = 0; ack_drv = 1'b0;
    end else if (scl && !scl_p) begin
      if (bitn < 8) begin
        sh = {sh[6:0], sda};
        bitn++;
        if (bitn == 8) rx.push_back(sh);
      end
    end else if (!scl && scl_p) begin
      if (bitn == 8) begin
        ack_drv = (byte_no != nack_at);
        bitn = 9;
      end else if (bitn == 9) begin
        ack_drv = 1'b0;
        bitn = 0;
        byte_no++;
      end
    end
    scl_p = scl;
    sda_p = sda;
  end

  int   cyc = 0, rise2_last = 0, per2 = 0;
  logic scl2_p = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (scl2 && !scl2_p) begin
      if (rise2_last != 0) per2 = cyc - rise2_last;
      rise2_last = cyc;
    end
    scl2_p = scl2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle request on DUT1; lat = cycles from the accept edge to done
  task automatic xfer(input logic [6:0] a, input logic [31:0] d, input logic [2:0] l,
                      output int lat, output logic nk1);
    @(negedge clk);
    chk("xfer_ready_before", cif.cfg_ready, 1'b1);
    cif.cfg_addr = a; cif.cfg_data = d; cif.cfg_len = l; cif.cfg_valid = 1'b1;
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    cif.cfg_addr  = 7'h7F; cif.cfg_data = 32'hFFFF_FFFF; cif.cfg_len = 3'd1;
    nk1 = cif.nack;
    chk("xfer_ready_busy", cif.cfg_ready, 1'b0);
    lat = 1;
    while (!cif.done && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    lat = lat - 1;
  endtask

  int   lat, base, s0, p0, dcnt;
  logic nk1;
  logic [7:0] exp_full [5] = '{8'h78, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] exp_b2b  [5] = '{8'h78, 8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    reset = 1'b1;
    cif.cfg_valid = 1'b0;  cif.cfg_addr = 7'h00;  cif.cfg_data = 32'h0;  cif.cfg_len = 3'd0;
    cif2.cfg_valid = 1'b0; cif2.cfg_addr = 7'h00; cif2.cfg_data = 32'h0; cif2.cfg_len = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cif.cfg_ready, 1'b1);
    chk("rst_done", cif.done, 1'b0);
    chk("rst_nack", cif.nack, 1'b0);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    reset = 1'b0;

    // Address probe
    base = rx.size(); s0 = nstart; p0 = nstop;
    xfer(7'h3C, 32'h0, 3'd0, lat, nk1);
    chk("probe_lat", lat, Q1 * 44);
    chk("probe_nack", cif.nack, 1'b0);
    chk("probe_nbytes", rx.size() - base, 1);
    chk("probe_byte", rx[base], 8'h78);
    chk("probe_start", nstart - s0, 1);
    chk("probe_stop", nstop - p0, 1);
    @(negedge clk);
    chk("probe_ready_after", cif.cfg_ready, 1'b1);
    chk("probe_done_pulse", cif.done, 1'b0);

    // Full write
    base = rx.size();
    xfer(7'h3C, 32'hA1B2C3D4, 3'd4, lat, nk1);
    chk("full_lat", lat, Q1 * 188);
    chk("full_nack", cif.nack, 1'b0);
    chk("full_nbytes", rx.size() - base, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("full_byte%0d", i), rx[base+i], exp_full[i]);

    // NACK on second data byte
    nack_at = 2;
    base = rx.size(); p0 = nstop;
    xfer(7'h3C, 32'h11223344, 3'd3, lat, nk1);
    chk("nack_lat", lat, Q1 * 116);
    chk("nack_flag", cif.nack, 1'b1);
    chk("nack_nbytes", rx.size() - base, 3);
    chk("nack_last_byte", rx[base+2], 8'h22);
    chk("nack_stop", nstop - p0, 1);
    nack_at = -1;
    xfer(7'h3C, 32'h0, 3'd0, lat, nk1);
    chk("nack_clear_on_accept", nk1, 1'b0);
    chk("nack_clear_end", cif.nack, 1'b0);

    // Clamp and back-to-back with cfg_valid held high
    base = rx.size(); s0 = nstart;
    @(negedge clk);
    cif.cfg_addr = 7'h3C; cif.cfg_data = 32'h01020304; cif.cfg_len = 3'd7; cif.cfg_valid = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cif.done && lat < 5000);
    chk("b2b_lat1", lat - 1, Q1 * 188);
    @(negedge clk);
    chk("b2b_accept_in_done", cif.cfg_ready, 1'b0);
    lat = 1;
    while (!cif.done && lat < 5000) begin @(negedge clk); lat++; end
    chk("b2b_lat2", lat - 1, Q1 * 188);
    cif.cfg_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle_ready", cif.cfg_ready, 1'b1);
    chk("b2b_nbytes", rx.size() - base, 10);
    chk("b2b_starts", nstart - s0, 2);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b_first%0d", i), rx[base+i], exp_b2b[i]);
      chk($sformatf("b2b_second%0d", i), rx[base+5+i], exp_b2b[i]);
    end

    // Reset during BIT of wire byte 2
    base = rx.size();
    @(negedge clk);
    cif.cfg_addr = 7'h3C; cif.cfg_data = 32'hA1B2C3D4; cif.cfg_len = 3'd4; cif.cfg_valid = 1'b1;
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    lat = 0;
    while (rx.size() - base < 2 && lat < 5000) begin @(negedge clk); lat++; end
    chk("rstmid_reached", rx.size() - base, 2);
    repeat (Q1 * 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_scl", scl, 1'b1);
    chk("rstmid_sda", sda, 1'b1);
    chk("rstmid_ready", cif.cfg_ready, 1'b1);
    chk("rstmid_done", cif.done, 1'b0);
    chk("rstmid_nack", cif.nack, 1'b0);
    reset = 1'b0;
    dcnt = 0;
    repeat (20) begin @(negedge clk); if (cif.done) dcnt++; end
    chk("rstmid_no_done", dcnt, 0);
    xfer(7'h3C, 32'h0, 3'd0, lat, nk1);
    chk("rstmid_after_lat", lat, Q1 * 44);
    chk("rstmid_after_nack", cif.nack, 1'b0);
    chk("rstmid_after_byte", rx[rx.size()-1], 8'h78);

    // Parametrised instance, no slave present on its bus
    @(negedge clk);
    cif2.cfg_addr = 7'h3C; cif2.cfg_len = 3'd0; cif2.cfg_valid = 1'b1;
    @(negedge clk);
    cif2.cfg_valid = 1'b0;
    lat = 1;
    while (!cif2.done && lat < 20000) begin @(negedge clk); lat++; end
    chk("param_lat", lat - 1, Q2 * 44);
    chk("param_scl_period", per2, Q2 * 4);
    chk("param_nack_noslave", cif2.nack, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
